io_request_bridge: RTL

Single-outstanding request sequencer sitting directly upstream of `memory_io`. It accepts CPU-side IO requests over a valid/ready handshake and drives `memory_io`'s `address_io`/`data_in_io`/`control_io` with the address-setup and strobe sequence its two-stage address pipeline requires. For reads it captures `data_out_io` after the fixed pipeline latency and returns it over a valid/ready response channel.

---
 rtl/io_request_bridge.sv | 138 +++++++++++++
 1 files changed

// File: rtl/io_request_bridge.sv
// io_request_bridge
//   Single-outstanding request sequencer in front of memory_io. It accepts one
//   CPU IO request at a time and holds the address for ACCESS_CYCLES cycles.
//   It then runs one FINAL cycle: a write strobes there, and a read captures
//   data_out_io there. The result goes out on a valid/ready response channel.
//
//   Optional feature macro: IO_BRIDGE_RANGE_CHECK_EN
//     defined   : requests outside the IO window are rejected without bus
//                 activity and answered with rsp_error=1.
//     undefined : every request is issued to the bus and rsp_error stays 0.
module io_request_bridge #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        main_clk,
    input  logic        main_reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [15:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_error,
    output logic [31:0] address_io,
    output logic [15:0] data_in_io,
    output logic [1:0]  control_io,
    input  logic [15:0] data_out_io
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_FINAL  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic             write_q, write_d;
    logic             byte_q, byte_d;
    logic [15:0]      rsp_data_q, rsp_data_d;
    logic             rsp_error_q, rsp_error_d;
    logic             run_q;
    logic             req_reject;
    logic             bus_active;

`ifdef IO_BRIDGE_RANGE_CHECK_EN
    // Only IO space (bit 31) with device select 0..2 may reach memory_io.
    assign req_reject = !req_address[31] || (req_address[25:20] > 6'd2);
`else
    assign req_reject = 1'b0;
`endif

    // Handshake and response outputs decode straight from registered state,
    // so an asynchronous reset clears them immediately.
    assign req_ready  = run_q && (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_error  = rsp_error_q;

    // Bus is driven only while a request is in flight; the strobe is FINAL-only.
    assign bus_active = (state_q == ST_ACCESS) || (state_q == ST_FINAL);
    assign address_io = bus_active ? addr_q : 32'h0;
    assign data_in_io = bus_active ? data_q : 16'h0;
    assign control_io = {(state_q == ST_FINAL) && write_q, bus_active && byte_q};

    // Next-state logic for the request sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        write_d     = write_q;
        byte_d      = byte_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d      = req_address;
                    data_d      = req_data;
                    write_d     = req_write;
                    byte_d      = req_byte;
                    cnt_d       = '0;
                    rsp_data_d  = 16'h0;
                    rsp_error_d = req_reject;
                    state_d     = req_reject ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_FINAL;
            end
            ST_FINAL: begin
                // memory_io's pipeline delivers read data during this cycle.
                if (!write_q) rsp_data_d = data_out_io;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers with asynchronous active-low reset.
    always_ff @(posedge main_clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= 32'h0;
            data_q      <= 16'h0;
            write_q     <= 1'b0;
            byte_q      <= 1'b0;
            rsp_data_q  <= 16'h0;
            rsp_error_q <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            write_q     <= write_d;
            byte_q      <= byte_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            run_q       <= 1'b1;
        end
    end

endmodule
